// File: rtl/time_display.sv
// ============================================================================
//  Module      : time_display
//  Description : Four-digit multiplexed seven-segment MM.SS display for the
//                elapsed time of one of two songs, with blink while paused.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module time_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       song_sel,
    input  logic       pause,
    input  logic [5:0] mins1,
    input  logic [5:0] secs1,
    input  logic [5:0] mins2,
    input  logic [5:0] secs2,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [REF_W-1:0] C_REF_MAX = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] C_BLK_MAX = BLK_W'(BLINK_DIV - 1);
    localparam logic [3:0] C_DASH = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CONV_MIN = 2'd1,
        S_CONV_SEC = 2'd2,
        S_LOAD     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               blk_off_q, blk_off_d;
    logic [23:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [5:0]         min_rem_q, min_rem_d, sec_rem_q, sec_rem_d;
    logic [2:0]         min_tens_q, min_tens_d, sec_tens_q, sec_tens_d;
    logic               min_dash_q, min_dash_d, sec_dash_q, sec_dash_d;
    logic [3:0]         dig3_q, dig3_d, dig2_q, dig2_d, dig1_q, dig1_d, dig0_q, dig0_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic               ref_wrap, frame_tick;
    logic [5:0]         sel_min, sel_sec;
    logic [3:0]         cur_digit;

    // Segment pattern {g,f,e,d,c,b,a}, active low; code 10 is the dash
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Digit scan timing: refresh counter and digit index, frame tick on 0->3
    always_comb begin
        ref_wrap   = (ref_cnt_q == C_REF_MAX);
        frame_tick = ref_wrap && (idx_q == 2'd0);
        ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        idx_d      = ref_wrap ? idx_q - 2'd1 : idx_q;
    end

    // Blink phase only runs while paused; otherwise held at counter 0, phase on
    always_comb begin
        blk_cnt_d = '0;
        blk_off_d = 1'b0;
        if (pause) begin
            if (blk_cnt_q == C_BLK_MAX) begin
                blk_cnt_d = '0;
                blk_off_d = ~blk_off_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
                blk_off_d = blk_off_q;
            end
        end
    end

    // Time fields come from the slow timer domain: two-flop synchronizer
    always_comb begin
        sync1_d = {mins1, secs1, mins2, secs2};
        sync2_d = sync1_q;
        sel_min = song_sel ? sync2_q[11:6] : sync2_q[23:18];
        sel_sec = song_sel ? sync2_q[5:0]  : sync2_q[17:12];
    end

    // Conversion FSM: sample on frame tick, divide by repeated subtraction,
    // then commit all four digits in one cycle so a frame never tears a field
    always_comb begin
        state_d    = state_q;
        min_rem_d  = min_rem_q;
        sec_rem_d  = sec_rem_q;
        min_tens_d = min_tens_q;
        sec_tens_d = sec_tens_q;
        min_dash_d = min_dash_q;
        sec_dash_d = sec_dash_q;
        dig3_d     = dig3_q;
        dig2_d     = dig2_q;
        dig1_d     = dig1_q;
        dig0_d     = dig0_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    // Out-of-range fields skip the division entirely
                    min_dash_d = (sel_min >= 6'd60);
                    sec_dash_d = (sel_sec >= 6'd60);
                    min_rem_d  = (sel_min >= 6'd60) ? 6'd0 : sel_min;
                    sec_rem_d  = (sel_sec >= 6'd60) ? 6'd0 : sel_sec;
                    min_tens_d = 3'd0;
                    sec_tens_d = 3'd0;
                    state_d    = S_CONV_MIN;
                end
            end
            S_CONV_MIN: begin
                if (min_rem_q < 6'd10) begin
                    state_d = S_CONV_SEC;
                end else begin
                    min_rem_d  = min_rem_q - 6'd10;
                    min_tens_d = min_tens_q + 3'd1;
                end
            end
            S_CONV_SEC: begin
                if (sec_rem_q < 6'd10) begin
                    state_d = S_LOAD;
                end else begin
                    sec_rem_d  = sec_rem_q - 6'd10;
                    sec_tens_d = sec_tens_q + 3'd1;
                end
            end
            default: begin
                dig3_d  = min_dash_q ? C_DASH : {1'b0, min_tens_q};
                dig2_d  = min_dash_q ? C_DASH : min_rem_q[3:0];
                dig1_d  = sec_dash_q ? C_DASH : {1'b0, sec_tens_q};
                dig0_d  = sec_dash_q ? C_DASH : sec_rem_q[3:0];
                state_d = S_IDLE;
            end
        endcase
    end

    // Output drive: one active-low enable per digit, decimal point after minutes
    always_comb begin
        case (idx_q)
            2'd3:    cur_digit = dig3_q;
            2'd2:    cur_digit = dig2_q;
            2'd1:    cur_digit = dig1_q;
            default: cur_digit = dig0_q;
        endcase
        if (blk_off_q) begin
            an_d  = 4'b1111;
            seg_d = 8'hFF;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = {(idx_q != 2'd2), seg_decode(cur_digit)};
        end
    end

    // State registers
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            ref_cnt_q  <= '0;
            idx_q      <= 2'd3;
            blk_cnt_q  <= '0;
            blk_off_q  <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            min_rem_q  <= '0;
            sec_rem_q  <= '0;
            min_tens_q <= '0;
            sec_tens_q <= '0;
            min_dash_q <= 1'b0;
            sec_dash_q <= 1'b0;
            dig3_q     <= '0;
            dig2_q     <= '0;
            dig1_q     <= '0;
            dig0_q     <= '0;
            an_q       <= 4'b1111;
            seg_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            idx_q      <= idx_d;
            blk_cnt_q  <= blk_cnt_d;
            blk_off_q  <= blk_off_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            min_rem_q  <= min_rem_d;
            sec_rem_q  <= sec_rem_d;
            min_tens_q <= min_tens_d;
            sec_tens_q <= sec_tens_d;
            min_dash_q <= min_dash_d;
            sec_dash_q <= sec_dash_d;
            dig3_q     <= dig3_d;
            dig2_q     <= dig2_d;
            dig1_q     <= dig1_d;
            dig0_q     <= dig0_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_time_display.sv
// ============================================================================
//  Module      : tb_time_display
//  Description : Self-checking bench for time_display (scan, convert, blink)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_time_display;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       song_sel = 1'b0;
    logic       pause = 1'b0;
    logic [5:0] mins1 = '0, secs1 = '0, mins2 = '0, secs2 = '0;
    logic [3:0] an, an2;
    logic [7:0] seg, seg2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];
    bit   blink_q[$];

    time_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) u_dut (
        .clk(clk), .RESET(RESET), .song_sel(song_sel), .pause(pause),
        .mins1(mins1), .secs1(secs1), .mins2(mins2), .secs2(secs2),
        .an(an), .seg(seg)
    );

    time_display #(.REFRESH_DIV(1), .BLINK_DIV(8)) u_dut2 (
        .clk(clk), .RESET(RESET), .song_sel(song_sel), .pause(pause),
        .mins1(mins1), .secs1(secs1), .mins2(mins2), .secs2(secs2),
        .an(an2), .seg(seg2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Push the four expected scan entries of a displayed MM.SS value
    task automatic push_frame(input int m, input int s);
        int mt, mo, st, so;
        exp_t e;
        mt = (m >= 60) ? 10 : m / 10;
        mo = (m >= 60) ? 10 : m % 10;
        st = (s >= 60) ? 10 : s / 10;
        so = (s >= 60) ? 10 : s % 10;
        e.an = 4'b0111; e.seg = {1'b1, enc(mt)}; exp_q.push_back(e);
        e.an = 4'b1011; e.seg = {1'b0, enc(mo)}; exp_q.push_back(e);
        e.an = 4'b1101; e.seg = {1'b1, enc(st)}; exp_q.push_back(e);
        e.an = 4'b1110; e.seg = {1'b1, enc(so)}; exp_q.push_back(e);
    endtask

    // Pop expectations as the matching digits are scanned out
    task automatic check_frame(input string name);
        exp_t e;
        int   n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = 0;
            @(negedge clk);
            while (an !== e.an && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (an !== e.an) begin
                errors++;
                $display("FAIL %s: timeout waiting for an=%b, last an=%b", name, e.an, an);
            end else if (seg !== e.seg) begin
                errors++;
                $display("FAIL %s: an=%b seg got %b expected %b", name, an, seg, e.seg);
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Align to the first cycle of a new frame (minutes-tens digit just enabled)
    task automatic wait_frame_start(input string name);
        int n = 0;
        @(negedge clk);
        while (an === 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (an !== 4'b0111 && n < 80) begin @(negedge clk); n++; end
        checks++;
        if (an !== 4'b0111) begin
            errors++;
            $display("FAIL %s: frame start not seen, an=%b", name, an);
        end
    endtask

    task automatic test_reset;
        wait_cycles(3);
        checks++;
        if (an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", seg); end
        checks++;
        if (an2 !== 4'b1111 || seg2 !== 8'hFF) begin
            errors++; $display("FAIL reset_dut2: got an=%b seg=%h expected 1111/ff", an2, seg2);
        end
        mins1 = 6'd12; secs1 = 6'd34;
        RESET = 1'b0;
        push_frame(0, 0);
        check_frame("post_reset_zero");
    endtask

    task automatic test_basic;
        wait_cycles(48);
        push_frame(12, 34);
        check_frame("basic_12_34");
    endtask

    task automatic test_song_switch;
        mins2 = 6'd59; secs2 = 6'd7;
        wait_cycles(40);
        wait_frame_start("switch_align");
        song_sel = 1'b1;
        push_frame(12, 34);
        check_frame("switch_old_frame");
        wait_cycles(32);
        push_frame(59, 7);
        check_frame("switch_new_59_07");
    endtask

    task automatic test_values;
        mins2 = 6'd48; secs2 = 6'd6;
        wait_cycles(48);
        push_frame(48, 6);
        check_frame("values_48_06");
    endtask

    task automatic test_dash;
        song_sel = 1'b0;
        mins1 = 6'd63; secs1 = 6'd60;
        wait_cycles(48);
        push_frame(63, 60);
        check_frame("dash");
    endtask

    task automatic test_reset_mid_conv;
        mins1 = 6'd12; secs1 = 6'd34;
        wait_cycles(48);
        wait_frame_start("rst_align");
        @(posedge clk);
        @(posedge clk);
        #1 RESET = 1'b1;
        #1;
        checks++;
        if (an !== 4'b1111 || seg !== 8'hFF) begin
            errors++; $display("FAIL reset_async: got an=%b seg=%h expected 1111/ff", an, seg);
        end
        wait_cycles(3);
        RESET = 1'b0;
        push_frame(0, 0);
        check_frame("reset_mid_conv_zero");
        wait_cycles(32);
        push_frame(12, 34);
        check_frame("reset_mid_conv_reload");
    endtask

    task automatic test_blink;
        bit off;
        @(negedge clk);
        pause = 1'b1;
        for (int c = 0; c < 40; c++) blink_q.push_back(((c / 8) % 2) == 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            off = blink_q.pop_front();
            checks++;
            if (off) begin
                if (an !== 4'b1111 || seg !== 8'hFF) begin
                    errors++;
                    $display("FAIL blink_off cycle %0d: got an=%b seg=%h expected 1111/ff", c, an, seg);
                end
            end else if (!(an inside {4'b0111, 4'b1011, 4'b1101, 4'b1110})) begin
                errors++;
                $display("FAIL blink_on cycle %0d: got an=%b expected one digit enabled", c, an);
            end
        end
        pause = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            checks++;
            if (!(an inside {4'b0111, 4'b1011, 4'b1101, 4'b1110})) begin
                errors++;
                $display("FAIL unpaused_scan cycle %0d: got an=%b expected one digit enabled", c, an);
            end
        end
    endtask

    // Fast-refresh instance: ticks arrive faster than conversions finish
    task automatic test_back_to_back;
        logic [7:0] want;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            case (an2)
                4'b0111: want = {1'b1, enc(1)};
                4'b1011: want = {1'b0, enc(2)};
                4'b1101: want = {1'b1, enc(3)};
                4'b1110: want = {1'b1, enc(4)};
                default: want = 8'hxx;
            endcase
            checks++;
            if (seg2 !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: an=%b seg got %b expected %b", c, an2, seg2, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_song_switch();
        test_values();
        test_dash();
        test_reset_mid_conv();
        test_blink();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 The block SHALL expose parameter REFRESH_DIV, default 100000, meaning the number of clk cycles each digit is driven (1 kHz digit rate at 100 MHz).
REQ-002 The block SHALL expose parameter BLINK_DIV, default 25000000, meaning the number of clk cycles per blink half-period while paused.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  system clock; RESET  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have these further ports: song_sel  input  1  0 = show song 1 time, 1 = show song 2 time.
REQ-005 pause  input  1  1 = playback paused, display blinks.
REQ-006 mins1, secs1, mins2, secs2  input  6 each  elapsed-time fields from the song timer, clk_1hz domain, nominal range 0..59.
REQ-007 an  output  4  active-low digit enables: an[3] = minutes tens, an[2] = minutes ones, an[1] = seconds tens, an[0] = seconds ones.
REQ-008 seg  output  8  active-low cathodes: seg[6:0] = {g,f,e,d,c,b,a}, seg[7] = decimal point.

Function
REQ-009 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the 2-bit digit index SHALL advance 3->2->1->0->3.
REQ-010 Exactly one an bit SHALL be low at a time, selected by the digit index, except during reset and blink-off phases.
REQ-011 A frame tick SHALL occur when the digit index wraps from 0 to 3.
REQ-012 On a frame tick the block SHALL sample the selected pair: {mins1, secs1} if song_sel=0, else {mins2, secs2}, passed through a 2-flop synchronizer.
REQ-013 A conversion FSM with states IDLE, CONV_MIN, CONV_SEC, LOAD SHALL convert each field to tens/ones by repeated subtraction of 10, one subtraction per clk.
REQ-014 IDLE->CONV_MIN on frame tick; CONV_MIN->CONV_SEC when the minutes remainder is <10; CONV_SEC->LOAD when the seconds remainder is <10; LOAD->IDLE unconditionally.
REQ-015 In LOAD, all four displayed digit registers SHALL update atomically; total latency from frame tick to update SHALL be at most 16 clk cycles.
REQ-016 A frame tick arriving while the FSM is not in IDLE SHALL be ignored.
REQ-017 A field value of 60..63 SHALL display a dash on both digits of that field (seg[6:0] = 7'b0111111).
REQ-018 Digit encodings (seg[6:0]) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Leading zeros are shown.
REQ-019 seg[7] SHALL be 0 (lit) only while an[2] is active, and 1 otherwise.
REQ-020 While pause=1, a blink counter SHALL count 0..BLINK_DIV-1 and toggle the blink phase on each wrap; during the off phase, an SHALL be 4'b1111 and seg SHALL be 8'hFF.
REQ-021 On pause rising, the blink phase SHALL start in the on phase with the counter at 0.
REQ-022 While pause=0, the blink counter SHALL be held at 0 and the phase SHALL be on.
REQ-023 A song_sel or input-value change during conversion SHALL NOT affect the conversion in progress; the change SHALL appear after the next frame tick.
REQ-024 an and seg SHALL be registered outputs.

Reset
REQ-025 While RESET=1: an=4'b1111, seg=8'hFF, refresh counter=0, digit index=3, FSM=IDLE, digit registers=0, blink counter=0, blink phase=on, synchronizers=0.
REQ-026 A RESET asserted mid-conversion SHALL abort it with no partial digit update.
REQ-027 After RESET deasserts, the display SHALL show 00.00 until the first LOAD.

Verification
REQ-028 REFRESH_DIV=4, song_sel=0, mins1=12, secs1=34, pause=0 -> after LOAD, the frame shows an[3]:1111001, an[2]:0100100 with seg[7]=0, an[1]:0110000, an[0]:0011001.
REQ-029 mins2=59, secs2=7, song_sel toggled 0->1 mid-conversion -> the current frame keeps song 1's digits; after the next frame tick the display shows 59.07.
REQ-030 mins1=63, secs1=60 -> all four digits show dash (0111111), and seg[7]=0 on an[2].
REQ-031 BLINK_DIV=8, pause=1 for 40 cycles -> an is 1111 during cycles 8-15 and 24-31 of the pause window; pause=0 -> digits are continuously scanned.
REQ-032 RESET pulsed while the FSM is in CONV_SEC -> an=1111 and seg=FF immediately; after release, the display shows 00.00, then the sampled value after the first LOAD.
REQ-033 Frame ticks forced back-to-back with an FSM still busy -> a single LOAD per accepted tick; no digit glitch is observed.
